// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED mode controller: mode encoding,
// per-mode start patterns and the mode sequencing function.
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_UP    = 3'd0,
        MODE_DOWN  = 3'd1,
        MODE_SHIFT = 3'd2,
        MODE_BLINK = 3'd3,
        MODE_HOLD  = 3'd4
    } mode_e;

    localparam int unsigned NUM_MODES = 5;

    localparam logic [3:0] PAT_UP_START    = 4'h0;
    localparam logic [3:0] PAT_DOWN_START  = 4'hF;
    localparam logic [3:0] PAT_SHIFT_START = 4'b0001;
    localparam logic [3:0] PAT_BLINK_START = 4'hF;

    // Cyclic advance; any illegal encoding falls back to MODE_UP.
    function automatic mode_e next_mode(input mode_e m);
        int unsigned idx;
        idx = 32'(m);
        if (idx >= NUM_MODES - 1)
            return MODE_UP;
        return mode_e'(3'(idx + 1));
    endfunction

    function automatic logic [3:0] start_pattern(input mode_e m, input logic [3:0] cur);
        case (m)
            MODE_UP:    return PAT_UP_START;
            MODE_DOWN:  return PAT_DOWN_START;
            MODE_SHIFT: return PAT_SHIFT_START;
            MODE_BLINK: return PAT_BLINK_START;
            default:    return cur;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: 2-FF synchronizer, stable-count debouncer and a
// press strobe that is high in the cycle before the debounced level falls.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2) begin : g_deb_check
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          settle;

    // settle marks the edge on which the debounced level flips.
    assign settle = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press  = settle && level;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED bank controller: tick prescaler, button-driven mode FSM and the 4-bit
// pattern register driving the active-low LED pins.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       btn_n,
    output logic       tick_out,
    output logic [2:0] mode_out,
    output logic [3:0] led_out
);

    localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("led_mode_ctrl: CLK_FREQ_HZ/TICK_HZ must be >= 2");
    end

    logic          press;
    logic          unused_btn_level;
    logic          tick;
    logic [PW-1:0] presc_q;
    mode_e         mode_q;
    mode_e         mode_d;
    logic [3:0]    pattern_q;
    logic [3:0]    pattern_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk   (clk),
        .n_rst (n_rst),
        .btn_n (btn_n),
        .level (unused_btn_level),
        .press (press)
    );

    assign tick = (presc_q == PW'(DIV - 1));

    // A press restarts the tick period so the new mode gets a full interval.
    always_ff @(posedge clk) begin
        if (!n_rst)
            presc_q <= '0;
        else if (press || tick)
            presc_q <= '0;
        else
            presc_q <= presc_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mode_q    <= MODE_UP;
            pattern_q <= PAT_UP_START;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        if (mode_q > MODE_HOLD) begin
            mode_d = MODE_UP;
        end else if (press) begin
            mode_d    = next_mode(mode_q);
            pattern_d = start_pattern(mode_d, pattern_q);
        end else if (tick) begin
            case (mode_q)
                MODE_UP:    pattern_d = pattern_q + 4'd1;
                MODE_DOWN:  pattern_d = pattern_q - 4'd1;
                MODE_SHIFT: pattern_d = {pattern_q[2:0], pattern_q[3]};
                MODE_BLINK: pattern_d = ~pattern_q;
                default:    pattern_d = pattern_q;
            endcase
        end
    end

    assign tick_out = tick;
    assign mode_out = mode_q;
    assign led_out  = ~pattern_q;

endmodule
